// File: rtl/stream_demux_1x8.sv
// 1-to-8 stream demultiplexer: one holding register per channel, destination
// chosen by in_sel or a round-robin pointer, plus an accepted-word counter.

module stream_demux_1x8_chan #(
   parameter int DW = 8
) (
   input  logic          clk,
   input  logic          rst,
   input  logic          load,
   input  logic [DW-1:0] load_data,
   input  logic          take,
   output logic          valid,
   output logic [DW-1:0] data
);
   logic          valid_q, valid_d;
   logic [DW-1:0] data_q, data_d;

   // A load on the same edge as a drain replaces the word and keeps valid set.
   always_comb begin
      valid_d = valid_q;
      data_d  = data_q;
      if (load) begin
         valid_d = 1'b1;
         data_d  = load_data;
      end else if (valid_q && take) begin
         valid_d = 1'b0;
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         valid_q <= 1'b0;
         data_q  <= '0;
      end else begin
         valid_q <= valid_d;
         data_q  <= data_d;
      end
   end

   assign valid = valid_q;
   assign data  = data_q;
endmodule

module stream_demux_1x8 #(
   parameter int DW = 8
) (
   input  logic            clk,
   input  logic            rst,
   input  logic            in_valid,
   output logic            in_ready,
   input  logic [DW-1:0]   in_data,
   input  logic [2:0]      in_sel,
   input  logic            rr_mode,
   output logic [7:0]      out_valid,
   input  logic [7:0]      out_ready,
   output logic [8*DW-1:0] out_data,
   output logic [2:0]      rr_ptr,
   output logic [15:0]     xfer_cnt
);
   logic [2:0]  rr_ptr_q, rr_ptr_d;
   logic [15:0] xfer_cnt_q, xfer_cnt_d;
   logic [2:0]  tgt;
   logic        xfer;
   logic [7:0]  load;

   // Round-robin never skips a busy channel; it stalls on it instead.
   always_comb begin
      tgt        = rr_mode ? rr_ptr_q : in_sel;
      in_ready   = !rst && (!out_valid[tgt] || out_ready[tgt]);
      xfer       = in_valid && in_ready;
      load       = '0;
      load[tgt]  = xfer;
      rr_ptr_d   = rr_ptr_q;
      xfer_cnt_d = xfer_cnt_q;
      if (xfer) begin
         xfer_cnt_d = xfer_cnt_q + 16'd1;
         if (rr_mode) rr_ptr_d = rr_ptr_q + 3'd1;
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         rr_ptr_q   <= '0;
         xfer_cnt_q <= '0;
      end else begin
         rr_ptr_q   <= rr_ptr_d;
         xfer_cnt_q <= xfer_cnt_d;
      end
   end

   for (genvar k = 0; k < 8; k++) begin : g_chan
      stream_demux_1x8_chan #(.DW(DW)) u_chan (
         .clk       (clk),
         .rst       (rst),
         .load      (load[k]),
         .load_data (in_data),
         .take      (out_ready[k]),
         .valid     (out_valid[k]),
         .data      (out_data[k*DW +: DW])
      );
   end

   assign rr_ptr   = rr_ptr_q;
   assign xfer_cnt = xfer_cnt_q;
endmodule

// File: doc/stream_demux_1x8.md
STREAM_DEMUX_1X8 -- requirements
Module: stream_demux_1x8

Interface
REQ-001 The module SHALL have parameter DW, default 8, meaning the data word width in bits.
REQ-002 The module SHALL have port clk, input, 1 bit: the single clock; all state updates on its rising edge.
REQ-003 The module SHALL have port rst, input, 1 bit: reset, synchronous and active-high.
REQ-004 The module SHALL have port in_valid, input, 1 bit: upstream word present.
REQ-005 The module SHALL have port in_ready, output, 1 bit: the block accepts the word this cycle.
REQ-006 The module SHALL have port in_data, input, DW bits: upstream word.
REQ-007 The module SHALL have port in_sel, input, 3 bits: destination channel 0-7 when rr_mode=0.
REQ-008 The module SHALL have port rr_mode, input, 1 bit: 1 = round-robin destination, 0 = in_sel destination.
REQ-009 The module SHALL have port out_valid, output, 8 bits: bit k = channel k holds a word.
REQ-010 The module SHALL have port out_ready, input, 8 bits: bit k = channel k consumer takes its word.
REQ-011 The module SHALL have port out_data, output, 8*DW bits: slice [k*DW +: DW] is the channel k word.
REQ-012 The module SHALL have port rr_ptr, output, 3 bits: current round-robin channel.
REQ-013 The module SHALL have port xfer_cnt, output, 16 bits: count of accepted input words.

Function
REQ-014 The target channel t SHALL be rr_ptr when rr_mode=1, else in_sel, evaluated combinationally each cycle.
REQ-015 Each channel SHALL contain exactly one holding register (valid flag plus DW-bit data); no other buffering.
REQ-016 in_ready SHALL equal !rst & (!out_valid[t] | out_ready[t]): pass-through from out_ready is permitted, with no other combinational input-to-output paths.
REQ-017 An input transfer SHALL occur when in_valid & in_ready; on that edge channel t loads in_data and sets out_valid[t]=1, for a latency of 1 cycle.
REQ-018 An output transfer on channel k SHALL occur when out_valid[k] & out_ready[k]; on that edge out_valid[k] clears unless a simultaneous input transfer targets k, in which case the new word loads and valid stays 1.
REQ-019 Non-target channels SHALL hold their data unchanged; out_data[k] SHALL be stable while out_valid[k]=1 and out_ready[k]=0.
REQ-020 Channels SHALL drain independently; any number of out_ready bits may be asserted in the same cycle.
REQ-021 rr_ptr SHALL increment by 1 on each input transfer while rr_mode=1, wrapping from 7 to 0.
REQ-022 rr_ptr SHALL hold when rr_mode=0 or when no transfer occurs; toggling rr_mode SHALL NOT modify rr_ptr.
REQ-023 When rr_mode=1 and channel rr_ptr is full and not draining, the block SHALL stall (in_ready=0) and SHALL NOT skip to another channel.
REQ-024 xfer_cnt SHALL increment by 1 per input transfer and wrap from 16'hFFFF to 0.
REQ-025 A change of in_sel while in_valid=1 and in_ready=0 SHALL re-evaluate t; upstream is responsible for holding in_sel stable.
REQ-026 Sustained throughput per channel SHALL be 1 word per cycle when that channel's out_ready is held at 1.

Reset
REQ-027 While rst=1 the block SHALL on each clock edge clear out_valid to 8'h00, out_data to 0, rr_ptr to 0 and xfer_cnt to 0, and SHALL force in_ready=0.
REQ-028 Reset asserted mid-operation SHALL discard all held words; no output transfer or counter update SHALL occur on a reset edge.
REQ-029 After rst deasserts, the first transfer SHALL be possible on the first clock edge with rst=0.

Verification
REQ-030 The bench SHALL cover: reset, then rr_mode=0, in_sel=5, in_data=8'hA5, in_valid for 1 cycle, out_ready=0 -> next cycle out_valid=8'h20, slice 5=8'hA5, xfer_cnt=1.
REQ-031 The bench SHALL cover: with channel 5 full, out_ready=0, a second word sent to in_sel=5 -> in_ready=0 and data held; then out_ready[5]=1 in the same cycle -> in_ready=1 and the new word replaces the old one with out_valid[5] staying 1.
REQ-032 The bench SHALL cover: rr_mode=1, out_ready=8'hFF, 9 back-to-back words 0..8 -> channels 0..7 receive words 0..7, channel 0 receives 8, and rr_ptr ends at 1.
REQ-033 The bench SHALL cover: rr_mode=1, out_ready=0, 8 words -> out_valid=8'hFF, then in_ready=0 at rr_ptr=0; setting out_ready[3] alone SHALL NOT unstall.
REQ-034 The bench SHALL cover: rst pulsed with 3 channels full -> next cycle out_valid=0, rr_ptr=0, xfer_cnt=0, and in_ready=0 during the pulse.
REQ-035 The bench SHALL cover: preload xfer_cnt to 16'hFFFF via 65535 transfers, then 1 more transfer -> xfer_cnt=0.
